// File: rtl/seq_wide_add_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_wide_add_sub_pkg
//  Description : Shared definitions for the sequential wide adder/subtractor:
//                operation select codes, FSM state encoding and a helper
//                that sizes the slice counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_wide_add_sub_pkg;

    // Operation select codes driven on the sel port.
    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    // Controller state encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Slice counter width: enough bits to index every slice, never zero.
    function automatic int cnt_width(input int nslices);
        return (nslices > 1) ? $clog2(nslices) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_wide_add_sub_rca_slice.sv
`default_nettype none
// ============================================================================
//  Module      : rca_slice
//  Description : Combinational SLICE-bit ripple-carry adder built from a
//                chain of full-adder cells.
//  Ports       : x, y   - slice operands (SLICE bits)
//                cin    - carry into bit 0
//                s      - slice sum (SLICE bits)
//                cout   - carry out of the top bit
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign cout = w_c[SLICE];

endmodule
`default_nettype wire

// File: rtl/seq_wide_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : seq_wide_add_sub
//  Description : Multi-cycle WIDTH-bit adder/subtractor. One SLICE-bit
//                ripple-carry adder is reused once per cycle, LSB slice
//                first, with the inter-slice carry held in a register.
//  Ports       : clk    - clock, all state on rising edge
//                rst_n  - synchronous active-low reset
//                start  - request, sampled only when busy=0
//                a, b   - operands (WIDTH bits)
//                sel    - 0: y=a+b, 1: y=a-b
//                busy   - operation in progress
//                done   - one-cycle pulse, y/cout/ovf valid
//                y      - result, held until next accepted start
//                cout   - final carry (sub: 1 = no borrow)
//                ovf    - signed overflow of the full-width result
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_wide_add_sub
    import seq_wide_add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    // WIDTH must be a multiple of SLICE.
    localparam int NSLICES = WIDTH / SLICE;
    localparam int CW      = cnt_width(NSLICES);
    localparam logic [CW-1:0] c_last = CW'(NSLICES - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_y;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_sum;
    logic             w_cout;

    // A new request is taken whenever no operation is in flight, so a start
    // presented during the DONE cycle chains straight into the next op.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == c_last);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slice selection and the shared slice adder
    // ------------------------------------------------------------------
    always_comb begin
        w_a_slice = r_a[32'(r_cnt) * SLICE +: SLICE];
        w_b_slice = r_b[32'(r_cnt) * SLICE +: SLICE];
    end

    rca_slice #(
        .SLICE (SLICE)
    ) u_rca_slice (
        .x    (w_a_slice),
        .y    (w_b_slice),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    // ------------------------------------------------------------------
    // Operand, carry, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert b once here and seed the
            // carry with sel so the slice adder only ever adds. The select
            // itself is fully captured by these two registers.
            r_a     <= a;
            r_b     <= (sel == SEL_SUB) ? ~b : b;
            r_carry <= sel;
            r_cnt   <= '0;
            r_y     <= '0;
        end else if (r_state == S_RUN) begin
            r_y[32'(r_cnt) * SLICE +: SLICE] <= w_sum;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_cout;
                // Overflow: conditioned operands share a sign that the
                // result does not.
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_sum[SLICE-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign y    = r_y;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_wide_add_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_wide_add_sub
//  Description : Self-checking bench for seq_wide_add_sub (WIDTH=16,
//                SLICE=4). Directed scenarios plus randomized operations
//                compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_wide_add_sub;

    localparam int WIDTH   = 16;
    localparam int SLICE   = 4;
    localparam int LATENCY = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    int n_vec;
    int n_err;

    seq_wide_add_sub #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain unsigned and signed integer arithmetic.
    function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                  input logic ms, output logic [WIDTH-1:0] my,
                                  output logic mc, output logic mo);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = $signed(ma);
        sb = $signed(mb);
        if (!ms) begin
            ur = ua + ub;
            sr = sa + sb;
            mc = (ur > 65535);
        end else begin
            ur = ua - ub;
            sr = sa - sb;
            mc = (ua >= ub);
        end
        my = WIDTH'(ur);
        mo = (sr > 32767) || (sr < -32768);
    endfunction

    // Present a request for one edge, then scramble the inputs.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic is);
        a = ia; b = ib; sel = is; start = 1'b1;
        tick();
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); sel = 1'($urandom);
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Wait (bounded) for done; lat counts cycles since the start edge.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic os,
                      input string tag);
        logic [WIDTH-1:0] ey;
        logic ec, eo;
        int lat;
        model(oa, ob, os, ey, ec, eo);
        issue(oa, ob, os);
        wait_done(1, lat);
        check({tag, "_latency"}, lat, LATENCY);
        check({tag, "_y"}, {16'd0, y}, {16'd0, ey});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [WIDTH-1:0] ra, rb, prev_y;
        logic rs;
        int gap;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sel = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_y",    {16'd0, y},    32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf",  {31'd0, ovf},  32'd0);
        rst_n = 1'b1;
        tick();

        // Directed cases with literal expectations.
        op(16'h00FF, 16'h0001, 1'b0, "carry_chain");
        check("carry_chain_lit", {16'd0, y, cout, ovf}, {16'd0, 16'h0100, 1'b0, 1'b0} >> 0 == 0 ? 32'd0 : {14'd0, 16'h0100, 2'b00});
        op(16'h1234, 16'h1234, 1'b1, "equal_sub");
        check("equal_sub_lit", {14'd0, y, cout, ovf}, {14'd0, 16'h0000, 2'b10});
        op(16'h0005, 16'h000A, 1'b1, "borrow");
        check("borrow_lit", {14'd0, y, cout, ovf}, {14'd0, 16'hFFFB, 2'b00});
        op(16'h7FFF, 16'h0001, 1'b0, "ovf_add");
        check("ovf_add_lit", {15'd0, y, ovf}, {15'd0, 16'h8000, 1'b1});
        op(16'h8000, 16'h0001, 1'b1, "ovf_sub");
        check("ovf_sub_lit", {14'd0, y, cout, ovf}, {14'd0, 16'h7FFF, 2'b11});

        // Busy guard: a second start mid-RUN must be ignored.
        tick();
        issue(16'h0010, 16'h0001, 1'b0);
        a = 16'hFFFF; b = 16'h0001; sel = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(2, lat);
        check("guard_latency", lat, LATENCY);
        check("guard_y", {16'd0, y}, 32'h0011);
        // Start held during DONE chains the next operation.
        issue(16'h0002, 16'h0001, 1'b1);
        check("b2b_no_done", {31'd0, done}, 32'd0);
        wait_done(1, lat);
        check("b2b_latency", lat, LATENCY);
        check("b2b_y", {16'd0, y}, 32'h0001);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("y_held", {16'd0, y}, 32'h0001);

        // Reset mid-RUN aborts with no done pulse.
        issue(16'h1111, 16'h2222, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_y",    {16'd0, y},    32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_ovf",  {31'd0, ovf},  32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // Randomized operations with random idle gaps (0 = back-to-back).
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            gap = int'($urandom_range(0, 2));
            prev_y = y;
            for (int g = 0; g < gap; g++) begin
                tick();
                check("gap_done_low", {31'd0, done}, 32'd0);
                check("gap_y_held", {16'd0, y}, {16'd0, prev_y});
            end
            op(ra, rb, rs, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
